fetch_stage: RTL and testbench

Instruction fetch stage directly upstream of the opcode control decoder. It holds the PC and fetches 16-bit instructions over a req/ack instruction-memory handshake with variable latency. It presents each instruction in an IF/ID register whose top nibble drives the decoder's opcode input. It honours decode stalls and redirects the PC on taken branches (BEZ), squashing wrong-path fetches.

---
 rtl/fetch_stage.sv | 135 +++++++++++++
 tb/tb_fetch_stage.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, req/ack instruction-memory fetch, IF/ID
// register and a one-entry hold buffer. Taken branches redirect the PC
// and squash any wrong-path fetch still in flight.
module fetch_stage #(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               id_stall,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [3:0]         if_opcode
);

  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_e;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } slot_t;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                ifv_q, ifv_d;
  slot_t               ifid_q, ifid_d;
  slot_t               hold_q, hold_d;
  logic                slot_free;

  // A new instruction may enter IF/ID when it is empty or being consumed.
  assign slot_free = !ifv_q || !id_stall;

  // State register; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= PC_RST;
      addr_q  <= PC_RST;
      ifv_q   <= 1'b0;
      ifid_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ifv_q   <= ifv_d;
      ifid_q  <= ifid_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic; a redirect overrides every other action in any state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    ifv_d   = ifv_q;
    ifid_d  = ifid_q;
    hold_d  = hold_q;
    if (br_taken) begin
      pc_d         = br_target;
      ifv_d        = 1'b0;
      ifid_d.instr = '0;
      hold_d       = '0;
    end
    unique case (state_q)
      IDLE: begin
        if (br_taken) addr_d = br_target;
        state_d = FETCH;
      end
      FETCH: begin
        if (br_taken) begin
          // An acked response is simply dropped; an outstanding one must be
          // drained on the old address before the redirect can be issued.
          if (imem_ack) addr_d = br_target;
          else          state_d = DRAIN;
        end else if (imem_ack) begin
          pc_d = addr_q + ONE;
          if (slot_free) begin
            ifid_d = '{instr: imem_rdata, pc: addr_q};
            ifv_d  = 1'b1;
            addr_d = addr_q + ONE;
          end else begin
            hold_d  = '{instr: imem_rdata, pc: addr_q};
            state_d = HOLD;
          end
        end else if (slot_free) begin
          ifv_d        = 1'b0;
          ifid_d.instr = '0;
        end
      end
      HOLD: begin
        if (br_taken) begin
          addr_d  = br_target;
          state_d = FETCH;
        end else if (!id_stall) begin
          ifid_d  = hold_q;
          ifv_d   = 1'b1;
          addr_d  = pc_q;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        // Wrong-path response is discarded; pc_d already carries the latest
        // redirect target.
        if (imem_ack) begin
          addr_d  = pc_d;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_req  = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr = addr_q;
  assign if_valid  = ifv_q;
  assign if_instr  = ifv_q ? ifid_q.instr : '0;
  assign if_pc     = ifid_q.pc;
  assign if_opcode = if_instr[INSTR_W-1 -: 4];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: latency-configurable memory responder plus a
// program-order reference model of the instruction stream.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        id_stall;
  logic        br_taken;
  logic [7:0]  br_target;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [7:0]  if_pc;
  logic [3:0]  if_opcode;

  fetch_stage #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_stall(id_stall), .br_taken(br_taken), .br_target(br_target),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_opcode(if_opcode)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         consumed = 0;
  int         wait_cnt = 0;
  int         lat = 0;
  bit         rand_lat = 1'b0;
  bit         op_mode = 1'b0;
  bit         squash = 1'b0;
  bit         last_ack = 1'b0;
  logic [7:0] exp_pc = 8'h00;

  // Memory contents as a function of address.
  function automatic logic [15:0] data_of(input logic [7:0] a);
    if (!op_mode) return {4'h1, 4'h0, a};
    return {a[3:0] ^ 4'h9, 4'hC, a};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; id_stall = 1'b0; br_taken = 1'b0; br_target = 8'h00;
    imem_ack = 1'b0; imem_rdata = 16'h0;
    exp_pc = 8'h00; squash = 1'b0; wait_cnt = 0; consumed = 0; last_ack = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: memory responds, the program-order model advances, then the
  // DUT outputs are compared against the model at the following negedge.
  task automatic tick();
    logic       pv, pst, pbr, preq, pack, ppres;
    logic [7:0] paddr;
    logic [15:0] expd;
    preq = imem_req; paddr = imem_addr;
    if (imem_req && wait_cnt >= lat) begin
      imem_ack = 1'b1; imem_rdata = data_of(imem_addr); wait_cnt = 0;
      if (rand_lat) lat = $urandom_range(0, 3);
    end else begin
      imem_ack = 1'b0; imem_rdata = 16'($urandom);
      if (imem_req) wait_cnt++;
    end
    pack = imem_ack; pv = if_valid; pst = id_stall; pbr = br_taken;
    ppres = pack && !squash && !pbr && (!pv || !pst);
    if (pbr) exp_pc = br_target;
    else if (pv && !pst) begin exp_pc = exp_pc + 8'h01; consumed++; end
    if (pack) squash = 1'b0;
    else if (pbr && preq) squash = 1'b1;
    last_ack = pack;
    @(posedge clk); @(negedge clk);
    if (preq && !pack) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== paddr) begin
        errors++;
        $display("FAIL addr_hold: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, paddr);
      end
    end
    if (pbr) begin
      checks++;
      if (if_valid !== 1'b0) begin
        errors++; $display("FAIL flush: if_valid=%b, required 0", if_valid);
      end
    end
    if (pv && pst && !pbr) begin
      checks++;
      if (if_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold: if_valid=%b, required 1", if_valid);
      end
    end
    if (ppres) begin
      checks++;
      if (if_valid !== 1'b1 || if_pc !== paddr) begin
        errors++;
        $display("FAIL ack_to_valid: valid=%b pc=%h, required 1/%h", if_valid, if_pc, paddr);
      end
    end
    checks++;
    if (if_valid) begin
      expd = data_of(exp_pc);
      if (if_pc !== exp_pc || if_instr !== expd || if_opcode !== expd[15:12]) begin
        errors++;
        $display("FAIL head: pc=%h instr=%h op=%h, required %h/%h/%h",
                 if_pc, if_instr, if_opcode, exp_pc, expd, expd[15:12]);
      end
    end else if (if_instr !== 16'h0 || if_opcode !== 4'h0) begin
      errors++;
      $display("FAIL nop: instr=%h op=%h, required 0000/0", if_instr, if_opcode);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!if_valid && n < 12) begin tick(); n++; end
    checks++;
    if (!if_valid) begin
      errors++; $display("FAIL %s_timeout: if_valid=0, required 1 within 12 cycles", name);
    end
  endtask

  task automatic test_reset();
    op_mode = 1'b0; rand_lat = 1'b0; lat = 0;
    rst_n = 1'b0; id_stall = 1'b0; br_taken = 1'b0; br_target = 8'h00;
    imem_ack = 1'b0; imem_rdata = 16'h0;
    exp_pc = 8'h00; squash = 1'b0; wait_cnt = 0; consumed = 0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 8'h00 || if_valid !== 1'b0 ||
        if_instr !== 16'h0 || if_pc !== 8'h00 || if_opcode !== 4'h0) begin
      errors++;
      $display("FAIL reset_values: req=%b addr=%h v=%b instr=%h pc=%h op=%h, required all 0",
               imem_req, imem_addr, if_valid, if_instr, if_pc, if_opcode);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL first_req: v=%b req=%b addr=%h, required 0/1/00", if_valid, imem_req, imem_addr);
    end
    tick();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 8'h00) begin
      errors++; $display("FAIL first_valid: v=%b pc=%h, required 1/00", if_valid, if_pc);
    end
  endtask

  task automatic test_zero_wait();
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 8'(k) || if_opcode !== 4'h1) begin
        errors++;
        $display("FAIL zero_wait: v=%b pc=%h op=%h, required 1/%h/1", if_valid, if_pc, if_opcode, 8'(k));
      end
    end
  endtask

  task automatic test_latency();
    do_reset(); lat = 3;
    repeat (30) tick();
    checks++;
    if (consumed < 5) begin
      errors++; $display("FAIL latency_progress: consumed=%0d, required >=5", consumed);
    end
    lat = 0;
  endtask

  task automatic test_stall();
    logic [7:0] p;
    do_reset(); lat = 0;
    repeat (4) tick();
    p = if_pc;
    id_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== p) begin
        errors++;
        $display("FAIL stall: req=%b v=%b pc=%h, required 0/1/%h", imem_req, if_valid, if_pc, p);
      end
    end
    id_stall = 1'b0;
    tick();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== p + 8'h01) begin
      errors++; $display("FAIL stall_release: v=%b pc=%h, required 1/%h", if_valid, if_pc, p + 8'h01);
    end
    tick();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== p + 8'h02) begin
      errors++; $display("FAIL stall_next: v=%b pc=%h, required 1/%h", if_valid, if_pc, p + 8'h02);
    end
  endtask

  task automatic test_branch_outstanding();
    int n = 0;
    bit seen = 1'b0;
    do_reset(); lat = 0;
    while (!(imem_req && imem_addr == 8'h05) && n < 20) begin tick(); n++; end
    checks++;
    if (!(imem_req && imem_addr == 8'h05)) begin
      errors++; $display("FAIL br_setup: addr=%h, required request to 05", imem_addr);
    end
    lat = 4; br_taken = 1'b1; br_target = 8'h40;
    tick();
    br_taken = 1'b0;
    n = 0;
    while (!seen && n < 10) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h05 || if_opcode !== 4'h0) begin
        errors++;
        $display("FAIL br_drain: req=%b addr=%h op=%h, required 1/05/0", imem_req, imem_addr, if_opcode);
      end
      tick(); n++;
      seen = last_ack;
    end
    checks++;
    if (!seen || imem_req !== 1'b1 || imem_addr !== 8'h40 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL br_redirect: ack=%b req=%b addr=%h v=%b, required 1/1/40/0", seen, imem_req, imem_addr, if_valid);
    end
    lat = 0;
    wait_valid("br_target");
    checks++;
    if (if_pc !== 8'h40) begin
      errors++; $display("FAIL br_first: pc=%h, required 40", if_pc);
    end
  endtask

  task automatic test_br_stall();
    logic [7:0] t;
    do_reset(); lat = 0;
    repeat (3) tick();
    t = 8'($urandom);
    id_stall = 1'b1; br_taken = 1'b1; br_target = t;
    tick();
    checks++;
    if (if_valid !== 1'b0) begin
      errors++; $display("FAIL br_stall_flush: v=%b, required 0", if_valid);
    end
    id_stall = 1'b0; br_taken = 1'b0;
    wait_valid("br_stall");
    checks++;
    if (if_pc !== t) begin
      errors++; $display("FAIL br_stall_resume: pc=%h, required %h", if_pc, t);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] e;
    do_reset(); lat = 0;
    repeat (2) tick();
    br_taken = 1'b1; br_target = 8'hFD;
    tick();
    br_taken = 1'b0;
    wait_valid("wrap");
    e = 8'hFD;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (if_valid !== 1'b1 || if_pc !== e || imem_addr !== e + 8'h01) begin
        errors++;
        $display("FAIL wrap: v=%b pc=%h addr=%h, required 1/%h/%h", if_valid, if_pc, imem_addr, e, e + 8'h01);
      end
      e = e + 8'h01;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset(); lat = 0;
    repeat (4) tick();
    lat = 5;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 8'h00 || if_valid !== 1'b0 ||
        if_instr !== 16'h0 || if_pc !== 8'h00 || if_opcode !== 4'h0) begin
      errors++;
      $display("FAIL async_reset: req=%b addr=%h v=%b instr=%h pc=%h op=%h, required all 0",
               imem_req, imem_addr, if_valid, if_instr, if_pc, if_opcode);
    end
    exp_pc = 8'h00; squash = 1'b0; wait_cnt = 0; lat = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 8'h00) begin
      errors++; $display("FAIL reset_restart: v=%b pc=%h, required 1/00", if_valid, if_pc);
    end
  endtask

  task automatic test_random();
    op_mode = 1'b1; rand_lat = 1'b1; lat = 0;
    do_reset();
    for (int k = 0; k < 800; k++) begin
      id_stall  = ($urandom_range(0, 9) < 3);
      br_taken  = ($urandom_range(0, 19) == 0);
      br_target = 8'($urandom);
      tick();
    end
    id_stall = 1'b0; br_taken = 1'b0;
    checks++;
    if (consumed < 80) begin
      errors++; $display("FAIL random_progress: consumed=%0d, required >=80", consumed);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_branch_outstanding();
    test_br_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
